// File: rtl/inst_buffer_pkg.sv
// rtl/inst_buffer_pkg.sv - shared fetch/dispatch packet type, NOP encoding and buffer depth
package inst_buffer_pkg;

    // Canonical no-op (addi x0, x0, 0) presented when nothing useful is available
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Default instruction buffer depth; must be a power of two and at least 4
    localparam int IB_DEPTH = 8;

    // Packet handed from fetch to the instruction buffer and on to dispatch
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        valid;
    } IF_IB_PACKET;

endpackage

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - circular instruction FIFO between fetch and dispatch
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = IB_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  IF_IB_PACKET                  if_ib_packet,
    input  logic                         squash,
    input  logic                         dp_pop,
    output logic                         ib_full,
    output logic                         ib_empty,
    output logic [$clog2(DEPTH+1)-1:0]   ib_count,
    output IF_IB_PACKET                  ib_dp_packet,
    output logic                         ib_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    // One slot is kept back for the packet fetch already has in flight
    localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    IF_IB_PACKET         entries [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic                squash_d;
    logic                overflow;

    logic                push_req;
    logic                push;
    logic                pop;

    // Decide this cycle's push/pop; the squash and the wrong-path packet after it never enter
    always_comb begin
        push_req = if_ib_packet.valid && !squash && !squash_d;
        pop      = dp_pop && (count != '0) && !squash;
        push     = push_req && ((count < CNT_FULL) || pop);
    end

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clock) begin
        if (push) begin
            entries[tail] <= if_ib_packet;
        end
    end

    // Pointers, occupancy and flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            squash_d <= 1'b0;
            overflow <= 1'b0;
        end else begin
            squash_d <= squash;
            if (push_req && !push) begin
                overflow <= 1'b1;
            end
            if (squash) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + PTR_ONE;
                end
                if (pop) begin
                    head <= head + PTR_ONE;
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // Status outputs derived from the registered occupancy
    always_comb begin
        ib_full     = (count >= CNT_THRESH);
        ib_empty    = (count == '0);
        ib_count    = count;
        ib_overflow = overflow;
    end

    // Head presentation: stored packet marked valid, or an invalid NOP when empty
    always_comb begin
        ib_dp_packet      = '0;
        ib_dp_packet.inst = NOP;
        if (count != '0) begin
            ib_dp_packet       = entries[head];
            ib_dp_packet.valid = 1'b1;
        end
    end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Circular FIFO between the fetch stage and dispatch. Each cycle it captures at most one valid IF_IB_PACKET from fetch and presents the oldest buffered packet to dispatch. Its ib_full output back-pressures fetch, with one entry held in reserve for the packet fetch already has in flight. A squash empties the buffer and discards the one wrong-path packet still arriving from fetch.

## Interface
- DEPTH, 8: number of entries; must be a power of two and at least 4.
- clock  in  1  sole clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low (asserted when 0); clears all state immediately.
- if_ib_packet  in  IF_IB_PACKET  packet from fetch; the entry is pushed only when .valid is 1.
- squash  in  1  flush request from branch recovery; same cycle as the fetch redirect.
- dp_pop  in  1  dispatch consumes the head entry this cycle.
- ib_full  out  1  back-pressure to fetch (fetch's `ib_full` input).
- ib_empty  out  1  no entries buffered.
- ib_count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- ib_dp_packet  out  IF_IB_PACKET  head entry to dispatch.
- ib_overflow  out  1  sticky error flag: a push was dropped because the buffer was full.

## Operation
- State:
  - entry array of DEPTH packets
  - head and tail pointers, $clog2(DEPTH) bits each; they wrap naturally at DEPTH.
  - count
  - squash_d flag (squash registered for one cycle)
  - overflow flag
- push_req = if_ib_packet.valid && !squash && !squash_d.
- pop = dp_pop && !ib_empty. A pop while empty is ignored and leaves state unchanged.
- push = push_req && (count < DEPTH || pop). Push and pop in the same cycle on a full buffer are legal; count stays at DEPTH.
- push_req when count == DEPTH and no pop: the packet is dropped and overflow is set. overflow stays set until reset.
- On push: entry[tail] <= if_ib_packet; tail++. On pop: head++.
- count next value = count + push - pop.
- squash:
  - Next cycle: head = tail = 0, count = 0.
  - Same-cycle push and pop are suppressed.
  - squash_d <= 1, so the packet fetch presents in the following cycle (fetched from the old PC) is also discarded.
  - A squash in consecutive cycles extends the discard window.
- Combinational outputs:
  - ib_full = (count >= DEPTH-1). This reserves the in-flight slot.
  - ib_empty = (count == 0).
  - ib_count = count.
- ib_dp_packet:
  - When not empty: entry[head] with .valid forced to 1.
  - When empty: all fields '0 except inst = `NOP; valid = 0.
- Wrong-path packets (fetch's NOP with valid=0) are never written.

## Timing
- Reset values:
  - count 0, head 0, tail 0, squash_d 0, overflow 0.
  - ib_empty 1, ib_full 0, ib_count 0.
  - ib_dp_packet in its empty form (inst = `NOP, valid = 0).
- Entry array contents need not be reset.
- Push-to-visibility latency is one cycle. A packet pushed at edge N is at the head from edge N onward if the buffer was empty. There is no same-cycle bypass.
- Pop takes effect at the edge. The next entry, or the empty form, is presented right after that edge.
- ib_full is combinational from registered count. Fetch sees it in the same cycle, and at most one further valid packet arrives. Threshold DEPTH-1 therefore prevents overflow for a compliant fetch.
- Reset asserted mid-operation clears everything asynchronously. The first push is possible at the first posedge after reset is released.

## Structure
- IF_IB_PACKET and `NOP come from the shared package and sys_defs; they are not redefined here.
- Add IB_DEPTH (8) to the shared package as the default for DEPTH.
- Single flat module; no sub-module is warranted.
- Pointer, count and flag updates go in one always_ff with asynchronous negedge reset.

## Test plan
- Reset, then 3 consecutive valid packets (PC 0x0, 0x4, 0x8) with dp_pop=0 -> ib_count = 1, 2, 3 after each edge; head PC stays 0x0; ib_empty goes 1→0 one cycle after the first push.
- DEPTH=8 fill without pop -> ib_full rises when ib_count reaches 7. The in-flight 8th packet is accepted (ib_count=8, ib_overflow=0). A 9th forced valid packet -> dropped, ib_overflow=1.
- Full buffer, push and pop in the same cycle -> ib_count stays 8; head advances by one entry; FIFO order is preserved across pointer wrap (PC 0x0..0x24 popped in order).
- ib_count=5, squash with a valid packet present, then a valid packet in the next cycle -> ib_count=0 and ib_empty=1; both packets discarded. The packet two cycles after squash is accepted (ib_count=1).
- Empty buffer, dp_pop=1 -> no state change; ib_dp_packet.valid=0 and inst=`NOP.
- reset driven low asynchronously mid-cycle with ib_count=4 -> all outputs return to reset values before the next posedge. Pushes resume normally after reset is released.
